// File: rtl/rope_move_judge.sv
// Tug-of-war answer judge: decides which player (if any) pulls the rope for each
// question, tracks the net rope position and declares the winner at +/-WIN_STEPS.
module rope_move_judge #(
  parameter int WIN_STEPS = 5
) (
  input  logic              clk_100mhz,
  input  logic              reset_n,
  input  logic              round_active,
  input  logic              round_clear,
  input  logic              new_question,
  input  logic              p1_submit,
  input  logic              p2_submit,
  input  logic [3:0]        p1_answer,
  input  logic [3:0]        p2_answer,
  input  logic [3:0]        correct_ans,
  output logic              move_left,
  output logic              move_right,
  output logic signed [3:0] step_pos,
  output logic              p1_locked,
  output logic              p2_locked,
  output logic              question_done,
  output logic              is_game_over,
  output logic [1:0]        winner_code
);

  typedef enum logic [1:0] {IDLE, ARMED, DONE, OVER} state_t;

  localparam logic signed [3:0] POS_WIN = 4'(WIN_STEPS);
  localparam logic signed [3:0] NEG_WIN = -POS_WIN;

  state_t            state_q;
  logic signed [3:0] step_q;
  logic              p1_lock_q, p2_lock_q;
  logic              mv_l_q, mv_r_q, qdone_q, over_q;
  logic [1:0]        winner_q;

  logic              p1_hit_s, p1_miss_s, p2_hit_s, p2_miss_s;
  logic signed [3:0] step_dn_s, step_up_s;

  always_comb begin
    p1_hit_s  = p1_submit & ~p1_lock_q & (p1_answer == correct_ans);
    p1_miss_s = p1_submit & ~p1_lock_q & (p1_answer != correct_ans);
    p2_hit_s  = p2_submit & ~p2_lock_q & (p2_answer == correct_ans);
    p2_miss_s = p2_submit & ~p2_lock_q & (p2_answer != correct_ans);
    step_dn_s = step_q - 4'sd1;
    step_up_s = step_q + 4'sd1;
  end

  // Game FSM; all outputs are registered and pulses default low every cycle.
  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      step_q    <= 4'sd0;
      p1_lock_q <= 1'b0;
      p2_lock_q <= 1'b0;
      mv_l_q    <= 1'b0;
      mv_r_q    <= 1'b0;
      qdone_q   <= 1'b0;
      over_q    <= 1'b0;
      winner_q  <= 2'b00;
    end else begin
      mv_l_q  <= 1'b0;
      mv_r_q  <= 1'b0;
      qdone_q <= 1'b0;
      if (round_clear) begin
        state_q   <= IDLE;
        step_q    <= 4'sd0;
        p1_lock_q <= 1'b0;
        p2_lock_q <= 1'b0;
        over_q    <= 1'b0;
        winner_q  <= 2'b00;
      end else begin
        case (state_q)
          IDLE: begin
            if (round_active) begin
              state_q   <= ARMED;
              p1_lock_q <= 1'b0;
              p2_lock_q <= 1'b0;
            end
          end
          ARMED: begin
            if (!round_active) begin
              state_q   <= IDLE;
              p1_lock_q <= 1'b0;
              p2_lock_q <= 1'b0;
            end else if (p1_hit_s && p2_hit_s) begin
              qdone_q <= 1'b1;
              state_q <= DONE;
            end else if (p1_hit_s) begin
              step_q    <= step_dn_s;
              mv_l_q    <= 1'b1;
              qdone_q   <= 1'b1;
              p2_lock_q <= p2_lock_q | p2_miss_s;
              if (step_dn_s == NEG_WIN) begin
                state_q  <= OVER;
                over_q   <= 1'b1;
                winner_q <= 2'b01;
              end else begin
                state_q <= DONE;
              end
            end else if (p2_hit_s) begin
              step_q    <= step_up_s;
              mv_r_q    <= 1'b1;
              qdone_q   <= 1'b1;
              p1_lock_q <= p1_lock_q | p1_miss_s;
              if (step_up_s == POS_WIN) begin
                state_q  <= OVER;
                over_q   <= 1'b1;
                winner_q <= 2'b10;
              end else begin
                state_q <= DONE;
              end
            end else begin
              p1_lock_q <= p1_lock_q | p1_miss_s;
              p2_lock_q <= p2_lock_q | p2_miss_s;
              // Nobody left who can answer: close the question without a move.
              if ((p1_lock_q | p1_miss_s) && (p2_lock_q | p2_miss_s)) begin
                qdone_q <= 1'b1;
                state_q <= DONE;
              end
            end
          end
          DONE: begin
            if (!round_active) begin
              state_q   <= IDLE;
              p1_lock_q <= 1'b0;
              p2_lock_q <= 1'b0;
            end else if (new_question) begin
              state_q   <= ARMED;
              p1_lock_q <= 1'b0;
              p2_lock_q <= 1'b0;
            end
          end
          OVER: begin
            state_q <= OVER;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign move_left     = mv_l_q;
  assign move_right    = mv_r_q;
  assign step_pos      = step_q;
  assign p1_locked     = p1_lock_q;
  assign p2_locked     = p2_lock_q;
  assign question_done = qdone_q;
  assign is_game_over  = over_q;
  assign winner_code   = winner_q;

endmodule

// File: tb/tb_rope_move_judge.sv
// Self-checking bench for rope_move_judge: directed scenarios plus random play,
// compared every cycle against a game-level reference model.
module tb_rope_move_judge;
  localparam int WIN = 5;
  localparam int PH_IDLE = 0, PH_ARMED = 1, PH_DONE = 2, PH_OVER = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n, round_active, round_clear, new_question;
  logic              p1_submit, p2_submit;
  logic [3:0]        p1_answer, p2_answer, correct_ans;
  logic              move_left, move_right, p1_locked, p2_locked;
  logic              question_done, is_game_over;
  logic signed [3:0] step_pos;
  logic [1:0]        winner_code;

  rope_move_judge #(.WIN_STEPS(WIN)) dut (
    .clk_100mhz(clk), .reset_n(reset_n), .round_active(round_active),
    .round_clear(round_clear), .new_question(new_question),
    .p1_submit(p1_submit), .p2_submit(p2_submit),
    .p1_answer(p1_answer), .p2_answer(p2_answer), .correct_ans(correct_ans),
    .move_left(move_left), .move_right(move_right), .step_pos(step_pos),
    .p1_locked(p1_locked), .p2_locked(p2_locked), .question_done(question_done),
    .is_game_over(is_game_over), .winner_code(winner_code)
  );

  int checks = 0;
  int errors = 0;

  // Reference game model: phase, net rope position, who is barred, result.
  int m_phase, m_pos, m_winner;
  bit m_l1, m_l2, m_over, e_ml, e_mr, e_qd;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = PH_IDLE; m_pos = 0; m_winner = 0;
    m_l1 = 0; m_l2 = 0; m_over = 0;
    e_ml = 0; e_mr = 0; e_qd = 0;
  endtask

  task automatic model_step();
    bit c1, c2, w1, w2;
    e_ml = 0; e_mr = 0; e_qd = 0;
    c1 = p1_submit && !m_l1 && (p1_answer == correct_ans);
    w1 = p1_submit && !m_l1 && (p1_answer != correct_ans);
    c2 = p2_submit && !m_l2 && (p2_answer == correct_ans);
    w2 = p2_submit && !m_l2 && (p2_answer != correct_ans);
    if (round_clear) begin
      model_reset();
    end else if (m_phase == PH_IDLE) begin
      if (round_active) begin m_phase = PH_ARMED; m_l1 = 0; m_l2 = 0; end
    end else if (m_phase == PH_ARMED) begin
      if (!round_active) begin
        m_phase = PH_IDLE; m_l1 = 0; m_l2 = 0;
      end else if (c1 && c2) begin
        e_qd = 1; m_phase = PH_DONE;
      end else if (c1 || c2) begin
        m_pos = m_pos + (c1 ? -1 : 1);
        e_ml = c1; e_mr = c2; e_qd = 1;
        if (w1) m_l1 = 1;
        if (w2) m_l2 = 1;
        if (m_pos == WIN || m_pos == -WIN) begin
          m_phase = PH_OVER; m_over = 1; m_winner = (m_pos < 0) ? 1 : 2;
        end else begin
          m_phase = PH_DONE;
        end
      end else begin
        if (w1) m_l1 = 1;
        if (w2) m_l2 = 1;
        if (m_l1 && m_l2) begin e_qd = 1; m_phase = PH_DONE; end
      end
    end else if (m_phase == PH_DONE) begin
      if (!round_active) begin m_phase = PH_IDLE; m_l1 = 0; m_l2 = 0; end
      else if (new_question) begin m_phase = PH_ARMED; m_l1 = 0; m_l2 = 0; end
    end
  endtask

  task automatic compare_all();
    logic [3:0] pe;
    pe = m_pos[3:0];
    check_eq("move_left", {7'd0, move_left}, {7'd0, e_ml});
    check_eq("move_right", {7'd0, move_right}, {7'd0, e_mr});
    check_eq("move_exclusive", {7'd0, move_left & move_right}, 8'd0);
    check_eq("question_done", {7'd0, question_done}, {7'd0, e_qd});
    check_eq("step_pos", {4'd0, step_pos}, {4'd0, pe});
    check_eq("p1_locked", {7'd0, p1_locked}, {7'd0, m_l1});
    check_eq("p2_locked", {7'd0, p2_locked}, {7'd0, m_l2});
    check_eq("is_game_over", {7'd0, is_game_over}, {7'd0, m_over});
    check_eq("winner_code", {6'd0, winner_code}, 8'(m_winner));
  endtask

  task automatic apply(input bit ra, input bit rc, input bit nq, input bit s1, input bit s2,
                       input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] ca);
    round_active = ra; round_clear = rc; new_question = nq;
    p1_submit = s1; p2_submit = s2;
    p1_answer = a1; p2_answer = a2; correct_ans = ca;
    model_step();
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    reset_n = 1'b0;
    round_active = 0; round_clear = 0; new_question = 0;
    p1_submit = 0; p2_submit = 0;
    p1_answer = 4'd0; p2_answer = 4'd0; correct_ans = 4'd0;
    model_reset();
    #1 compare_all();
    repeat (2) @(negedge clk);
    compare_all();
    reset_n = 1'b1;

    // P1 answers correctly on the first question
    apply(1, 0, 0, 0, 0, 4'd0, 4'd0, 4'd7); tick();
    apply(1, 0, 0, 1, 0, 4'd7, 4'd0, 4'd7); tick();
    check_eq("p1_win_pos", {4'd0, step_pos}, 8'h0F);
    check_eq("p1_win_left", {7'd0, move_left}, 8'd1);
    check_eq("p1_win_done", {7'd0, question_done}, 8'd1);

    // Both wrong one after another
    apply(1, 0, 1, 0, 0, 4'd0, 4'd0, 4'd3); tick();
    apply(1, 0, 0, 1, 0, 4'd2, 4'd0, 4'd3); tick();
    check_eq("p1_wrong_lock", {7'd0, p1_locked}, 8'd1);
    apply(1, 0, 0, 0, 1, 4'd0, 4'd2, 4'd3); tick();
    check_eq("both_wrong_done", {7'd0, question_done}, 8'd1);
    check_eq("both_wrong_lock2", {7'd0, p2_locked}, 8'd1);
    check_eq("both_wrong_pos", {4'd0, step_pos}, 8'h0F);
    apply(1, 0, 0, 1, 1, 4'd3, 4'd3, 4'd3); tick();
    check_eq("both_wrong_once", {7'd0, question_done}, 8'd0);

    // Tie: both correct in the same cycle
    apply(1, 0, 1, 0, 0, 4'd0, 4'd0, 4'd5); tick();
    apply(1, 0, 0, 1, 1, 4'd5, 4'd5, 4'd5); tick();
    check_eq("tie_done", {7'd0, question_done}, 8'd1);
    check_eq("tie_nomove", {6'd0, move_left, move_right}, 8'd0);
    check_eq("tie_pos", {4'd0, step_pos}, 8'h0F);

    // P2 wins five in a row from centre
    apply(1, 1, 0, 0, 0, 4'd0, 4'd0, 4'd9); tick();
    apply(1, 0, 0, 0, 0, 4'd0, 4'd0, 4'd9); tick();
    for (int i = 1; i <= WIN; i++) begin
      apply(1, 0, 0, 0, 1, 4'd0, 4'd9, 4'd9); tick();
      check_eq("p2_run_right", {7'd0, move_right}, 8'd1);
      check_eq("p2_run_pos", {4'd0, step_pos}, 8'(i));
      if (i < WIN) begin
        apply(1, 0, 1, 0, 0, 4'd0, 4'd0, 4'd9); tick();
      end
    end
    check_eq("p2_win_over", {7'd0, is_game_over}, 8'd1);
    check_eq("p2_win_code", {6'd0, winner_code}, 8'd2);
    apply(1, 0, 1, 0, 0, 4'd0, 4'd0, 4'd9); tick();
    apply(1, 0, 0, 0, 1, 4'd0, 4'd9, 4'd9); tick();
    check_eq("over_nomove", {7'd0, move_right}, 8'd0);
    check_eq("over_hold_pos", {4'd0, step_pos}, 8'd5);

    // Clear from OVER, then reset with a move pending
    apply(1, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0); tick();
    check_eq("clear_pos", {4'd0, step_pos}, 8'd0);
    check_eq("clear_code", {6'd0, winner_code}, 8'd0);
    apply(1, 0, 0, 0, 0, 4'd0, 4'd0, 4'd4); tick();
    apply(1, 0, 0, 1, 0, 4'd4, 4'd0, 4'd4);
    #2 reset_n = 1'b0;
    #1 model_reset();
    compare_all();
    @(posedge clk);
    #1 check_eq("reset_no_move", {6'd0, move_left, question_done}, 8'd0);
    @(negedge clk);
    reset_n = 1'b1;
    apply(0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0); tick();

    // Random play
    for (int n = 0; n < 4000; n++) begin
      logic [3:0] ca, a1, a2;
      ca = 4'($urandom_range(0, 15));
      a1 = ($urandom_range(0, 1) == 0) ? ca : 4'($urandom_range(0, 15));
      a2 = ($urandom_range(0, 1) == 0) ? ca : 4'($urandom_range(0, 15));
      apply($urandom_range(0, 29) != 0, $urandom_range(0, 79) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, a1, a2, ca);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rope_move_judge.md
ROPE_MOVE_JUDGE -- requirements
Module: rope_move_judge

Interface
REQ-001 SHALL have parameter WIN_STEPS, default 5, net rope steps from centre that ends the game (legal 1..7).
REQ-002 SHALL have port clk_100mhz  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port round_active  input  1  high while the game controller is in its answer-wait state.
REQ-005 SHALL have port round_clear  input  1  single-cycle pulse, re-centres rope and clears game result.
REQ-006 SHALL have port new_question  input  1  single-cycle pulse, new question presented, re-arms judging.
REQ-007 SHALL have ports p1_submit, p2_submit  input  1 each  debounced single-cycle submit events.
REQ-008 SHALL have ports p1_answer, p2_answer, correct_ans  input  4 each  player answers and expected answer.
REQ-009 SHALL have ports move_left, move_right  output  1 each  single-cycle step commands to the rope position counter (left = toward P1).
REQ-010 SHALL have port step_pos  output  4  signed two's-complement net steps, negative = P1 side.
REQ-011 SHALL have ports p1_locked, p2_locked  output  1 each  player barred from current question.
REQ-012 SHALL have port question_done  output  1  single-cycle pulse, current question resolved.
REQ-013 SHALL have ports is_game_over  output  1, winner_code  output  2 (00 none, 01 P1, 10 P2).

Function
REQ-014 SHALL implement states IDLE, ARMED, DONE, OVER.
REQ-015 IDLE: round_active=1 -> ARMED with both locks cleared; all submits ignored.
REQ-016 ARMED: a submit from an unlocked player is judged correct when its 4-bit answer equals correct_ans in the submit cycle.
REQ-017 P1 correct alone: move_left=1 exactly one cycle after the submit, step_pos decremented, question_done pulsed in the same cycle, -> DONE.
REQ-018 P2 correct alone: move_right=1 one cycle after the submit, step_pos incremented, question_done same cycle, -> DONE.
REQ-019 Both correct in same cycle: tie, no move pulse, question_done one cycle later, -> DONE.
REQ-020 One correct, other wrong, same cycle: correct player wins the step per REQ-017/018; wrong player locked.
REQ-021 Wrong submit: that player's lock set one cycle later; remain ARMED.
REQ-022 Both players locked: question_done one cycle later, no move, -> DONE.
REQ-023 Submits from a locked player, or in IDLE/DONE/OVER, SHALL be ignored.
REQ-024 DONE: new_question -> ARMED with both locks cleared in the next cycle.
REQ-025 When a step makes step_pos = -WIN_STEPS: -> OVER, is_game_over=1, winner_code=01 in the same cycle as the move pulse; +WIN_STEPS gives winner_code=10.
REQ-026 OVER: holds step_pos, winner_code, is_game_over; ignores all inputs except round_clear.
REQ-027 round_clear (any state, priority over all else): -> IDLE next cycle, step_pos=0, locks=0, is_game_over=0, winner_code=00, no pulses.
REQ-028 round_active falling in ARMED or DONE: -> IDLE, step_pos retained, locks cleared.
REQ-029 move_left and move_right SHALL never be high together; at most one move per question.
REQ-030 step_pos SHALL never exceed +/-WIN_STEPS (no wrap).

Reset
REQ-031 reset_n=0 SHALL asynchronously force IDLE, step_pos=0, all outputs 0, winner_code=00.
REQ-032 Reset deassertion mid-question SHALL start in IDLE with no pending move or question_done pulse.

Verification
REQ-033 IDLE, round_active=1, correct_ans=7, p1_submit with p1_answer=7 -> move_left one cycle later, step_pos=-1, question_done=1, state DONE.
REQ-034 ARMED, correct_ans=3, p1_answer=2 submit, then p2_answer=2 submit -> both locked, question_done once, no move, step_pos unchanged.
REQ-035 ARMED, correct_ans=5, p1 and p2 both submit 5 same cycle -> no move, question_done=1, step_pos unchanged.
REQ-036 Five consecutive P2-correct questions from step_pos=0, WIN_STEPS=5 -> fifth move_right with step_pos=+5, is_game_over=1, winner_code=10; further correct submits produce no move.
REQ-037 In OVER, round_clear pulse -> IDLE, step_pos=0, winner_code=00; reset_n=0 during a pending move -> no move pulse emitted, outputs 0 immediately.
